byte_assembler: RTL

Receive-side counterpart of the message transmitter FSM: packs consecutive N-bit bytes from the UART RX module into one M-bit message register. Bytes arrive MSB-first: the first byte received lands in `data[M-1:M-N]`. The completed message is presented with a valid/ack handshake to the register file. Sits between the UART RX module and the register/consumer logic in the uart-to-reg design.

---
 rtl/uart_pkg.sv | 19 +
 rtl/idle_timer.sv | 28 ++
 rtl/byte_assembler.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Constants and FSM state encoding shared by the UART message transmitter and
// receiver (byte_assembler).
package uart_pkg;

  localparam int unsigned N_DEF     = 8;
  localparam int unsigned M_DEF     = 128;
  localparam int unsigned BYTES_DEF = M_DEF / N_DEF;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  // The byte counter never holds BYTES itself, so clog2(BYTES) bits suffice.
  function automatic int unsigned cnt_width(input int unsigned bytes);
    return (bytes > 1) ? $clog2(bytes) : 1;
  endfunction

endpackage

// File: rtl/idle_timer.sv
// Inter-byte idle counter for byte_assembler: counts cycles while run=1.
// expired is high in the TIMEOUT-th consecutive cycle without a restart.
module idle_timer #(
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  input  logic run,
  output logic expired
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] r_count;

  // A restart in the expiry cycle takes priority over expiry.
  assign expired = run && !restart && (r_count == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!reset || restart || !run) begin
      r_count <= '0;
    end else if (!expired) begin
      r_count <= r_count + TW'(1);
    end
  end

endmodule

// File: rtl/byte_assembler.sv
// Packs BYTES consecutive N-bit RX characters (MSB-first) into one M-bit
// message and hands it to the consumer with a valid/ack handshake.
// Optional inter-byte idle timeout: define BYTE_ASSEMBLER_TIMEOUT_EN.
//
// Handshake: data is meaningful while valid=1; ack in a cycle with valid=1
// consumes it. A completion with valid=1 and no ack drops the new message and
// sets overrun (sticky until ack). rx_valid is a strobe with no back-pressure.
module byte_assembler
  import uart_pkg::*;
#(
  parameter int unsigned N       = N_DEF,
  parameter int unsigned M       = M_DEF,
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rx_valid,
  input  logic [N-1:0] rx_data,
  input  logic         rx_error,
  input  logic         ack,
  output logic [M-1:0] data,
  output logic         valid,
  output logic         overrun,
  output logic         timeout,
  output state_t       dbg_state
);

  localparam int unsigned BYTES = M / N;
  localparam int unsigned CW    = cnt_width(BYTES);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [M-1:0]  r_shreg;
  logic [M-1:0]  r_data;
  logic          r_valid;
  logic          r_overrun;

  state_t        w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [M-1:0]  w_shreg_nxt;
  logic [M-1:0]  w_shifted;
  logic          w_good;
  logic          w_last;
  logic          w_complete;
  logic          w_expired;

  assign w_shifted = (r_shreg << N) | {{(M-N){1'b0}}, rx_data};
  assign w_good    = rx_valid && !rx_error;
  assign w_last    = (r_cnt == CW'(BYTES - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shreg_nxt = r_shreg;
    w_complete  = 1'b0;
    if (rx_valid && rx_error) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
      w_shreg_nxt = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_good) begin
            w_shreg_nxt = w_shifted;
            if (w_last) begin
              w_complete = 1'b1;
            end else begin
              w_cnt_nxt   = CW'(1);
              w_state_nxt = COLLECT;
            end
          end
        end
        COLLECT: begin
          if (w_good) begin
            w_shreg_nxt = w_shifted;
            if (w_last) begin
              w_complete  = 1'b1;
              w_cnt_nxt   = '0;
              w_state_nxt = IDLE;
            end else begin
              w_cnt_nxt = r_cnt + CW'(1);
            end
          end else if (w_expired) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_shreg_nxt = '0;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_shreg   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shreg <= w_shreg_nxt;
      // An ack in the completion cycle frees the output register for the new message.
      if (w_complete && (!r_valid || ack)) begin
        r_data  <= w_shifted;
        r_valid <= 1'b1;
      end else if (ack) begin
        r_valid <= 1'b0;
      end
      if (w_complete && r_valid && !ack) begin
        r_overrun <= 1'b1;
      end else if (ack && r_valid) begin
        r_overrun <= 1'b0;
      end
    end
  end

`ifdef BYTE_ASSEMBLER_TIMEOUT_EN
  logic w_run;
  logic r_timeout;

  assign w_run = (r_state == COLLECT);

  idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_idle_timer (
    .clk     (clk),
    .reset   (reset),
    .restart (rx_valid),
    .run     (w_run),
    .expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_expired;
    end
  end

  assign timeout = r_timeout;
`else
  assign w_expired = 1'b0;
  assign timeout   = 1'b0;
`endif

  assign data      = r_data;
  assign valid     = r_valid;
  assign overrun   = r_overrun;
  assign dbg_state = r_state;

endmodule
